// File: rtl/grf_traced_if.sv
// Register-file bus: two read ports, one write port (with the writer's PC),
// and the trace FIFO drain handshake.
interface grf_traced_if #(
  parameter int WIDTH       = 32,
  parameter int ADDR_W      = 5,
  parameter int PC_W        = 32,
  parameter int TRACE_DEPTH = 8
);
  localparam int CNT_W = $clog2(TRACE_DEPTH) + 1;

  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [WIDTH-1:0]  rd1;
  logic [WIDTH-1:0]  rd2;
  logic              we;
  logic [ADDR_W-1:0] a3;
  logic [WIDTH-1:0]  wd3;
  logic [PC_W-1:0]   pc;
  logic              trace_valid;
  logic              trace_ready;
  logic [PC_W-1:0]   trace_pc;
  logic [ADDR_W-1:0] trace_addr;
  logic [WIDTH-1:0]  trace_data;
  logic [CNT_W-1:0]  trace_count;
  logic [15:0]       drop_cnt;

  // Decode/writeback side and trace consumer.
  modport master (
    output a1, a2, we, a3, wd3, pc, trace_ready,
    input  rd1, rd2, trace_valid, trace_pc, trace_addr, trace_data,
           trace_count, drop_cnt
  );

  // Register file side.
  modport slave (
    input  a1, a2, we, a3, wd3, pc, trace_ready,
    output rd1, rd2, trace_valid, trace_pc, trace_addr, trace_data,
           trace_count, drop_cnt
  );
endinterface

// File: rtl/grf_traced.sv
// General register file with a write-trace FIFO.
// Two combinational read ports, one synchronous write port, x0 hardwired to
// zero, optional write-to-read bypass. Every committed write is logged as
// {pc, addr, data} in a first-word-fall-through FIFO; overflow drops the
// entry (never the register write) and bumps a saturating drop counter.
module grf_traced #(
  parameter int WIDTH       = 32,
  parameter int ADDR_W      = 5,
  parameter int BYPASS      = 0,
  parameter int TRACE_DEPTH = 8,
  parameter int PC_W        = 32
) (
  input logic         clk,
  input logic         reset,
  grf_traced_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PTR_W = $clog2(TRACE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } trace_entry_t;

  logic [WIDTH-1:0] regs     [DEPTH];
  trace_entry_t     fifo_mem [TRACE_DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [15:0]      drop_q;

  logic commit;
  logic full;
  logic pop;
  logic push_ok;
  logic drop;

  // A write commits (and requests a trace entry) only when it reaches a real register.
  assign commit  = bus.we && !reset && (bus.a3 != '0);
  assign full    = (count == CNT_W'(TRACE_DEPTH));
  assign pop     = (count != '0) && bus.trace_ready;
  // When full, a simultaneous pop frees the slot the push reuses.
  assign push_ok = commit && (!full || pop);
  assign drop    = commit && full && !pop;

  // Register array: cleared on reset, x0 is never written.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  // NOTE: the register array is reset because software relies on zeroed registers;
  // the trace storage below is not, since count gates every read of it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[bus.a3] <= bus.wd3;
    end
  end

  // Read port 1: zero for x0, optional same-cycle bypass of the in-flight write.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    bus.rd1 = regs[bus.a1];
    if ((BYPASS != 0) && commit && (bus.a3 == bus.a1)) bus.rd1 = bus.wd3;
    if (bus.a1 == '0) bus.rd1 = '0;
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    bus.rd2 = regs[bus.a2];
    if ((BYPASS != 0) && commit && (bus.a3 == bus.a2)) bus.rd2 = bus.wd3;
    if (bus.a2 == '0) bus.rd2 = '0;
  end

  // Trace storage: write the new entry at the tail slot.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[tail] <= '{pc: bus.pc, addr: bus.a3, data: bus.wd3};
  end

  // Trace pointers, occupancy and saturating drop counter; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      drop_q <= '0;
    end else begin
      if (push_ok) tail <= tail + 1'b1;
      if (pop)     head <= head + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  // Head entry falls through to the outputs.
  assign bus.trace_valid = (count != '0);
  assign bus.trace_pc    = fifo_mem[head].pc;
  assign bus.trace_addr  = fifo_mem[head].addr;
  assign bus.trace_data  = fifo_mem[head].data;
  assign bus.trace_count = count;
  assign bus.drop_cnt    = drop_q;
endmodule

// File: tb/tb_grf_traced.sv
// Bench for grf_traced: two instances (BYPASS=0 and BYPASS=1) share one
// stimulus stream and are compared against a queue-based reference model.
module tb_grf_traced;
  localparam int TD = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  a1, a2, a3;
  logic [31:0] wd3, pc;
  logic        ready;

  always #5 clk = ~clk;

  grf_traced_if #(.WIDTH(32), .ADDR_W(5), .PC_W(32), .TRACE_DEPTH(TD)) ifa ();
  grf_traced_if #(.WIDTH(32), .ADDR_W(5), .PC_W(32), .TRACE_DEPTH(TD)) ifb ();

  assign ifa.a1 = a1;  assign ifa.a2 = a2;  assign ifa.we = we;
  assign ifa.a3 = a3;  assign ifa.wd3 = wd3; assign ifa.pc = pc;
  assign ifa.trace_ready = ready;
  assign ifb.a1 = a1;  assign ifb.a2 = a2;  assign ifb.we = we;
  assign ifb.a3 = a3;  assign ifb.wd3 = wd3; assign ifb.pc = pc;
  assign ifb.trace_ready = ready;

  grf_traced #(.WIDTH(32), .ADDR_W(5), .BYPASS(0), .TRACE_DEPTH(TD), .PC_W(32))
    dut_b0 (.clk(clk), .reset(reset), .bus(ifa));
  grf_traced #(.WIDTH(32), .ADDR_W(5), .BYPASS(1), .TRACE_DEPTH(TD), .PC_W(32))
    dut_b1 (.clk(clk), .reset(reset), .bus(ifb));

  // Reference model: plain register array, trace log as a queue.
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  logic [31:0] m_regs [32];
  entry_t      m_q [$];
  int          m_drop;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [31:0] pc;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] rd1_b0, rd1_b1, rd2_b0, rd2_b1;
    int          count;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && we && !reset && a3 == a) return wd3;
    return m_regs[a];
  endfunction

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step();
    bit do_pop;
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_q.delete();
      m_drop = 0;
    end else begin
      do_pop = (m_q.size() != 0) && ready;
      if (do_pop) void'(m_q.pop_front());
      if (we && a3 != 0) begin
        m_regs[a3] = wd3;
        if (m_q.size() < TD) m_q.push_back('{pc: pc, addr: a3, data: wd3});
        else if (m_drop < 16'hFFFF) m_drop++;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reads();
    check("rd1_b0", 64'(ifa.rd1), 64'(exp_rd(a1, 0)));
    check("rd2_b0", 64'(ifa.rd2), 64'(exp_rd(a2, 0)));
    check("rd1_b1", 64'(ifb.rd1), 64'(exp_rd(a1, 1)));
    check("rd2_b1", 64'(ifb.rd2), 64'(exp_rd(a2, 1)));
  endtask

  task automatic check_state();
    check("count_b0", 64'(ifa.trace_count), 64'(m_q.size()));
    check("count_b1", 64'(ifb.trace_count), 64'(m_q.size()));
    check("valid_b0", 64'(ifa.trace_valid), 64'(m_q.size() != 0));
    check("drop_b0",  64'(ifa.drop_cnt), 64'(m_drop));
    check("drop_b1",  64'(ifb.drop_cnt), 64'(m_drop));
    if (m_q.size() != 0) begin
      check("head_pc",   64'(ifa.trace_pc),   64'(m_q[0].pc));
      check("head_addr", 64'(ifa.trace_addr), 64'(m_q[0].addr));
      check("head_data", 64'(ifa.trace_data), 64'(m_q[0].data));
      check("head_data_b1", 64'(ifb.trace_data), 64'(m_q[0].data));
    end
  endtask

  task automatic idle();
    we = 1'b0; a3 = '0; wd3 = '0; pc = '0; ready = 1'b0;
  endtask

  task automatic write(input logic [4:0] addr, input logic [31:0] data, input logic [31:0] p);
    we = 1'b1; a3 = addr; wd3 = data; pc = p;
    #1;
    check_reads();
    tick();
    check_state();
  endtask

  // Pop until the model is empty (bounded), then confirm the DUT is empty too.
  task automatic drain();
    idle();
    ready = 1'b1;
    for (int i = 0; i < TD + 4 && m_q.size() != 0; i++) begin
      check_state();
      tick();
    end
    check_state();
    check("drained_valid", 64'(ifa.trace_valid), 64'(0));
    ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 32'h3000, 5'd5, 5'd0,
                32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 1};
    vecs[1] = '{1'b1, 5'd0, 32'h00001234, 32'h3004, 5'd0, 5'd5,
                32'h0, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1};
    vecs[2] = '{1'b1, 5'd7, 32'hA5A5A5A5, 32'h3008, 5'd5, 5'd7,
                32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'hA5A5A5A5, 2};
    vecs[3] = '{1'b0, 5'd7, 32'h0, 32'h0, 5'd7, 5'd7,
                32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 2};
    vecs[4] = '{1'b1, 5'd7, 32'h11111111, 32'h300C, 5'd7, 5'd5,
                32'hA5A5A5A5, 32'h11111111, 32'hDEADBEEF, 32'hDEADBEEF, 3};
    vecs[5] = '{1'b0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd0,
                32'h11111111, 32'h11111111, 32'h0, 32'h0, 3};

    // Reset state.
    reset = 1'b1; a1 = '0; a2 = '0;
    idle();
    tick();
    tick();
    reset = 1'b0;
    check_state();
    a1 = 5'd5; a2 = 5'd31;
    #1;
    check("reset_rd1", 64'(ifa.rd1), 64'(0));
    check("reset_rd2", 64'(ifb.rd2), 64'(0));

    // Directed vectors: reads sampled before the edge, occupancy after it.
    for (int i = 0; i < 6; i++) begin
      we = vecs[i].we; a3 = vecs[i].a3; wd3 = vecs[i].wd3; pc = vecs[i].pc;
      a1 = vecs[i].a1; a2 = vecs[i].a2; ready = 1'b0;
      #1;
      check($sformatf("vec%0d_rd1_b0", i), 64'(ifa.rd1), 64'(vecs[i].rd1_b0));
      check($sformatf("vec%0d_rd1_b1", i), 64'(ifb.rd1), 64'(vecs[i].rd1_b1));
      check($sformatf("vec%0d_rd2_b0", i), 64'(ifa.rd2), 64'(vecs[i].rd2_b0));
      check($sformatf("vec%0d_rd2_b1", i), 64'(ifb.rd2), 64'(vecs[i].rd2_b1));
      tick();
      check($sformatf("vec%0d_count", i), 64'(ifa.trace_count), 64'(vecs[i].count));
      check_state();
    end
    check("first_addr", 64'(ifa.trace_addr), 64'(5));
    check("first_pc",   64'(ifa.trace_pc),   64'(32'h3000));
    check("first_data", 64'(ifa.trace_data), 64'(32'hDEADBEEF));

    // Overflow: 10 writes with no drain into an 8-deep log.
    reset = 1'b1; idle(); tick(); reset = 1'b0;
    for (int i = 1; i <= 10; i++) write(5'(i), $urandom, 32'h4000 + 32'(4 * i));
    check("ovf_count", 64'(ifa.trace_count), 64'(8));
    check("ovf_drop",  64'(ifa.drop_cnt),    64'(2));
    idle();
    for (int i = 1; i <= 10; i++) begin
      a1 = 5'(i);
      #1;
      check($sformatf("ovf_reg%0d", i), 64'(ifa.rd1), 64'(m_regs[i]));
    end
    drain();

    // Full log with simultaneous push and pop, running long enough to wrap.
    for (int i = 0; i < TD; i++) write(5'($urandom_range(1, 31)), $urandom, 32'h5000 + 32'(i));
    ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      we = 1'b1; a3 = 5'($urandom_range(1, 31)); wd3 = $urandom; pc = 32'h6000 + 32'(i);
      a1 = a3; a2 = 5'($urandom_range(0, 31));
      #1;
      check_reads();
      tick();
      check("pp_count", 64'(ifa.trace_count), 64'(8));
      check("pp_drop",  64'(ifa.drop_cnt),    64'(2));
      check_state();
    end
    drain();

    // Reset during a drain flushes the log and clears the drop count.
    for (int i = 0; i < 4; i++) write(5'(20 + i), $urandom, 32'h7000 + 32'(i));
    idle();
    ready = 1'b1;
    tick();
    check_state();
    reset = 1'b1; we = 1'b1; a3 = 5'd9; wd3 = 32'hCAFEF00D;
    tick();
    reset = 1'b0;
    idle();
    check("rst_count", 64'(ifa.trace_count), 64'(0));
    check("rst_valid", 64'(ifa.trace_valid), 64'(0));
    check("rst_drop",  64'(ifa.drop_cnt),    64'(0));
    for (int i = 0; i < 32; i++) begin
      a1 = 5'(i);
      #1;
      check($sformatf("rst_reg%0d", i), 64'(ifa.rd1), 64'(0));
    end
    check_state();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      we    = ($urandom_range(0, 3) != 0);
      a3    = 5'($urandom_range(0, 31));
      wd3   = $urandom;
      pc    = $urandom;
      ready = ($urandom_range(0, 2) == 0);
      a1    = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
      a2    = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
      #1;
      check_reads();
      tick();
      check_state();
    end
    reset = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
